// File: rtl/led_serial_rx.sv
// Purpose: recover channel words and latch-delimited frames from an LED-driver serial chain.
// Latency: o_valid 3 i_clk cycles after the first i_clk edge that samples the final i_clk_ser high.
// Backpressure: none; outputs are pulses/held registers, and the consumer must keep up.
//
// Ports:
//   i_clk, i_rst_n          system clock, async active-low reset
//   i_clk_ser, i_dai, i_lat asynchronous serial clock, data (MSB first) and latch strobe
//   o_data, o_chan, o_valid last completed word, its index in the frame, one-cycle update pulse
//   o_frame, o_count, o_err latch pulse, words in the last frame, last frame malformed
module led_serial_rx #(
  parameter int c_width = 12,
  parameter int c_chans = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_ser,
  input  logic               i_dai,
  input  logic               i_lat,
  output logic [c_width-1:0] o_data,
  output logic [7:0]         o_chan,
  output logic               o_valid,
  output logic               o_frame,
  output logic [7:0]         o_count,
  output logic               o_err
);

  localparam int              BW        = $clog2(c_width);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(c_width - 1);
  localparam logic [7:0]      MAX_CHANS = 8'(c_chans);

  // [0],[1] form the synchronizer, [2] is the edge-detect history flop.
  logic [2:0]         ser_sync;
  logic [2:0]         lat_sync;
  logic [1:0]         dai_sync;
  // Data capture flop sits at the same pipeline depth as the registered edge
  // pulses, so the bit taken is the one present when i_clk_ser rose.
  logic               dai_q;
  logic               ser_rise_q;
  logic               lat_rise_q;
  logic [1:0]         arm_cnt;
  logic               armed;

  logic [c_width-1:0] shreg;
  logic [c_width-1:0] shifted;
  logic [BW-1:0]      bit_cnt;
  logic [7:0]         word_idx;

  // Edges are ignored until the synchronizers have filled with post-reset
  // samples, so an input already high at release is not seen as a rise.
  assign armed   = (arm_cnt == 2'd3);
  assign shifted = {shreg[c_width-2:0], dai_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ser_sync   <= '0;
      lat_sync   <= '0;
      dai_sync   <= '0;
      dai_q      <= 1'b0;
      ser_rise_q <= 1'b0;
      lat_rise_q <= 1'b0;
      arm_cnt    <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_idx   <= '0;
      o_data     <= '0;
      o_chan     <= '0;
      o_valid    <= 1'b0;
      o_frame    <= 1'b0;
      o_count    <= '0;
      o_err      <= 1'b0;
    end else begin
      ser_sync   <= {ser_sync[1:0], i_clk_ser};
      lat_sync   <= {lat_sync[1:0], i_lat};
      dai_sync   <= {dai_sync[0], i_dai};
      dai_q      <= dai_sync[1];
      ser_rise_q <= armed & ser_sync[1] & ~ser_sync[2];
      lat_rise_q <= armed & lat_sync[1] & ~lat_sync[2];
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end

      o_valid <= 1'b0;
      o_frame <= 1'b0;

      if (lat_rise_q) begin
        // A shift edge coinciding with the latch is dropped and flags the frame.
        o_frame  <= 1'b1;
        o_count  <= word_idx;
        o_err    <= (bit_cnt != '0) || (word_idx > MAX_CHANS) || ser_rise_q;
        bit_cnt  <= '0;
        word_idx <= '0;
        shreg    <= '0;
      end else if (ser_rise_q) begin
        shreg <= shifted;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          o_data  <= shifted;
          o_chan  <= word_idx;
          o_valid <= 1'b1;
          if (word_idx != 8'hFF) begin
            word_idx <= word_idx + 8'd1;
          end
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_serial_rx.sv
// Purpose: scoreboard bench for led_serial_rx; words and frames are queued as driven, popped as the DUT reports them.
// Latency: each word's o_valid is checked against the cycle its final serial clock rise was sampled.
// Backpressure: none; the monitor consumes every pulse.
module tb_led_serial_rx;

  logic        i_clk     = 1'b0;
  logic        i_rst_n   = 1'b0;
  logic        i_clk_ser = 1'b0;
  logic        i_dai     = 1'b0;
  logic        i_lat     = 1'b0;
  logic [11:0] o_data;
  logic [7:0]  o_chan;
  logic        o_valid;
  logic        o_frame;
  logic [7:0]  o_count;
  logic        o_err;

  int cyc      = 0;
  int rise_cyc = 0;
  int n_chk    = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_frame  = 0;

  int exp_data[$];
  int exp_chan[$];
  int exp_cnt[$];
  int exp_err[$];

  led_serial_rx #(.c_width(12), .c_chans(16)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clk_ser (i_clk_ser),
    .i_dai     (i_dai),
    .i_lat     (i_lat),
    .o_data    (o_data),
    .o_chan    (o_chan),
    .o_valid   (o_valid),
    .o_frame   (o_frame),
    .o_count   (o_count),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: sample #1 after the rising edge.
  always @(posedge i_clk) begin
    #1;
    if (o_valid) begin
      n_valid++;
      chk("valid_expected", 32'(exp_data.size() != 0), 1);
      if (exp_data.size() != 0) begin
        chk("word_data", 32'(o_data), exp_data.pop_front());
        chk("word_chan", 32'(o_chan), exp_chan.pop_front());
        chk("valid_latency", cyc - rise_cyc, 3);
      end
    end
    if (o_frame) begin
      n_frame++;
      chk("frame_expected", 32'(exp_cnt.size() != 0), 1);
      if (exp_cnt.size() != 0) begin
        chk("frame_count", 32'(o_count), exp_cnt.pop_front());
        chk("frame_err", 32'(o_err), exp_err.pop_front());
      end
    end
  end

  task automatic expect_word(input int d, input int c);
    exp_data.push_back(d);
    exp_chan.push_back(c);
  endtask

  task automatic expect_frame(input int cnt, input int err);
    exp_cnt.push_back(cnt);
    exp_err.push_back(err);
  endtask

  task automatic send_bit(input logic b);
    @(negedge i_clk);
    i_dai = b;
    repeat (4) @(negedge i_clk);
    i_clk_ser = 1'b1;
    rise_cyc  = cyc + 1;  // the next posedge is the first to sample it high
    repeat (4) @(negedge i_clk);
    i_clk_ser = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic latch();
    @(negedge i_clk);
    i_lat = 1'b1;
    repeat (4) @(negedge i_clk);
    i_lat = 1'b0;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_data.size() + exp_cnt.size()) != 0 && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    chk("drain", 32'(exp_data.size() + exp_cnt.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {1'b0, o_data, o_chan, o_valid, o_frame, o_count, o_err}, 0);
  endtask

  initial begin
    int d;
    // Reset held with inputs toggling.
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      i_clk_ser = ~i_clk_ser;
      i_dai     = i[1];
      i_lat     = i[2];
      if (i % 4 == 3) chk_all_zero("reset_outputs");
    end
    // Inputs high across release: no edge may be seen.
    @(negedge i_clk);
    i_clk_ser = 1'b1;
    i_dai     = 1'b1;
    i_lat     = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("release_no_valid", n_valid, 0);
    chk("release_no_frame", n_frame, 0);
    i_clk_ser = 1'b0;
    i_dai     = 1'b0;
    i_lat     = 1'b0;
    repeat (6) @(negedge i_clk);

    // Single word frame.
    expect_word(12'hA5C, 0);
    send_bits(32'hA5C, 12);
    expect_frame(1, 0);
    latch();
    drain();

    // Three words.
    expect_word(12'h001, 0); send_bits(32'h001, 12);
    expect_word(12'h800, 1); send_bits(32'h800, 12);
    expect_word(12'hFFF, 2); send_bits(32'hFFF, 12);
    expect_frame(3, 0);
    latch();
    drain();
    chk("data_hold", 32'(o_data), 32'hFFF);
    chk("count_hold", 32'(o_count), 3);

    // 13 bits: one word plus a stray bit, then a clean frame.
    expect_word(12'h5A3, 0);
    send_bits(32'h5A3, 12);
    send_bit(1'b1);
    expect_frame(1, 1);
    latch();
    drain();
    chk("err_hold", 32'(o_err), 1);
    expect_word(12'h0F0, 0);
    send_bits(32'h0F0, 12);
    expect_frame(1, 0);
    latch();
    drain();

    // Overlong frame: 17 words against 16 channels.
    for (int i = 0; i < 17; i++) begin
      d = (i * 37 + 5) & 12'hFFF;
      expect_word(d, i);
      send_bits(32'(d), 12);
    end
    expect_frame(17, 1);
    latch();
    drain();
    chk("chan_reached_16", 32'(o_chan), 16);

    // Shift clock and latch rising together: bit dropped, frame flagged.
    expect_word(12'h321, 0);
    send_bits(32'h321, 12);
    @(negedge i_clk);
    i_dai = 1'b1;
    repeat (4) @(negedge i_clk);
    i_clk_ser = 1'b1;
    i_lat     = 1'b1;
    expect_frame(1, 1);
    repeat (4) @(negedge i_clk);
    i_clk_ser = 1'b0;
    i_lat     = 1'b0;
    repeat (4) @(negedge i_clk);
    drain();
    // Dropped bit must not leak into the next frame.
    expect_word(12'h456, 0);
    send_bits(32'h456, 12);
    expect_frame(1, 0);
    latch();
    drain();

    // Reset in the middle of a word.
    send_bits(32'h2A, 6);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_all_zero("midword_reset_outputs");
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    expect_word(12'h3C3, 0);
    send_bits(32'h3C3, 12);
    expect_frame(1, 0);
    latch();
    drain();
    chk("after_reset_data", 32'(o_data), 32'h3C3);

    chk("valid_total", n_valid, 26);
    chk("frame_total", n_frame, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
